matmul_core_dispatcher: RTL and testbench

//  Parametrised launch/completion controller for NUM_CORES matrix-multiplier cores. A rising edge on
//  i_start issues a one-cycle start pulse to every enabled core, checks that each core raises busy, and

---
 rtl/matmul_core_dispatcher.sv | 124 ++++++++++++
 tb/tb_matmul_core_dispatcher.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_core_dispatcher.sv
// Launch/completion controller for NUM_CORES matrix-multiplier cores: start pulse, busy-ack check, run wait, done pulse.
// Optional run-cycle counter is built only when MATMUL_PERF_CNT_EN is defined; otherwise o_cycle_count is tied to 0.
module matmul_core_dispatcher #(
  parameter int unsigned NUM_CORES   = 4,
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [NUM_CORES-1:0] i_core_en,
  input  logic [NUM_CORES-1:0] i_core_busy,
  output logic [NUM_CORES-1:0] o_core_start,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic [NUM_CORES-1:0] o_err_core,
  output logic [CNT_W-1:0]     o_cycle_count
);

  localparam int unsigned TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_ACK    = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t               state;
  logic                 start_q;
  logic                 start_edge;
  logic [NUM_CORES-1:0] mask;
  logic [NUM_CORES-1:0] ack;
  logic [NUM_CORES-1:0] ack_nxt;
  logic [NUM_CORES-1:0] busy_m;
  logic [TMR_W-1:0]     timer;
  logic                 err;
  logic [NUM_CORES-1:0] err_core;
  logic                 run_active;

  assign start_edge = i_start & ~start_q;
  assign busy_m     = i_core_busy & mask;
  assign ack_nxt    = ack | busy_m;
  assign run_active = (state == S_LAUNCH) || (state == S_ACK) || (state == S_RUN);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      start_q  <= 1'b0;
      mask     <= '0;
      ack      <= '0;
      timer    <= '0;
      err      <= 1'b0;
      err_core <= '0;
    end else begin
      start_q <= i_start;
      case (state)
        S_IDLE: begin
          if (start_edge) begin
            mask     <= i_core_en;
            err      <= (i_core_en == '0);
            err_core <= '0;
            state    <= (i_core_en == '0) ? S_DONE : S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          ack   <= '0;
          timer <= '0;
          state <= S_ACK;
        end
        S_ACK: begin
          ack   <= ack_nxt;
          timer <= timer + TMR_W'(1);
          if (ack_nxt == mask) begin
            state <= S_RUN;
          end else if (timer == TMR_W'(ACK_TIMEOUT - 1)) begin
            // Silent cores are dropped from the mask so RUN only waits on cores that answered.
            err      <= 1'b1;
            err_core <= mask & ~ack_nxt;
            mask     <= ack_nxt;
            state    <= (ack_nxt == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (busy_m == '0) state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_core_start = (state == S_LAUNCH) ? mask : '0;
  assign o_busy       = run_active;
  assign o_done       = (state == S_DONE);
  assign o_err        = err;
  assign o_err_core   = err_core;

`ifdef MATMUL_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt;

  // Cleared on the accepting edge, saturates at all-ones, holds after DONE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cycle_cnt <= '0;
    end else if ((state == S_IDLE) && start_edge) begin
      cycle_cnt <= '0;
    end else if (run_active && (cycle_cnt != '1)) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

  assign o_cycle_count = cycle_cnt;
`else
  assign o_cycle_count = '0;
`endif

endmodule

// File: tb/tb_matmul_core_dispatcher.sv
// Randomized bench for matmul_core_dispatcher: per-run busy waveforms are scanned by a timeline model
// that predicts every output on every cycle; a few directed runs pin the model with literal values.
`timescale 1ns/1ps
module tb_matmul_core_dispatcher;
  localparam int NC   = 4;
  localparam int AT   = 16;
  localparam int CW   = 32;
  localparam int MAXC = 128;
`ifdef MATMUL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [NC-1:0] core_en;
  logic [NC-1:0] core_busy;
  logic [NC-1:0] core_start;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic [NC-1:0] err_core;
  logic [CW-1:0] cyc_cnt;

  always #5 clk = ~clk;

  matmul_core_dispatcher #(
    .NUM_CORES  (NC),
    .ACK_TIMEOUT(AT),
    .CNT_W      (CW)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_core_en    (core_en),
    .i_core_busy  (core_busy),
    .o_core_start (core_start),
    .o_busy       (busy_o),
    .o_done       (done_o),
    .o_err        (err_o),
    .o_err_core   (err_core),
    .o_cycle_count(cyc_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Expected outputs for the current cycle, written by the stimulus process.
  logic          chk_en = 1'b0;
  int            cyc = 0;
  logic [NC-1:0] e_start = '0;
  logic          e_busy = 1'b0;
  logic          e_done = 1'b0;
  logic          e_err = 1'b0;
  logic [NC-1:0] e_err_core = '0;
  logic [CW-1:0] e_cnt = '0;

  // Literal-expectation mailbox; the compare process is the only place comparisons happen.
  string       lit_name = "";
  logic [63:0] lit_act = '0;
  logic [63:0] lit_exp = '0;
  int          lit_seq = 0;
  int          lit_seen = 0;

  // Observations of o_done pulses, owned by the compare process.
  int            obs_done_total = 0;
  int            obs_done_cyc = -1;
  logic [CW-1:0] obs_cnt = '0;
  logic          obs_err = 1'b0;
  logic [NC-1:0] obs_err_core = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t cyc=%0d: got %0h, expected %0h", name, $time, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("core_start", 64'(core_start), 64'(e_start));
      check("busy",       64'(busy_o),     64'(e_busy));
      check("done",       64'(done_o),     64'(e_done));
      check("err",        64'(err_o),      64'(e_err));
      check("err_core",   64'(err_core),   64'(e_err_core));
      check("cycle_count", 64'(cyc_cnt),   64'(e_cnt));
      if (done_o === 1'b1) begin
        obs_done_total++;
        obs_done_cyc = cyc;
        obs_cnt      = cyc_cnt;
        obs_err      = err_o;
        obs_err_core = err_core;
      end
    end
    if (lit_seq != lit_seen) begin
      check(lit_name, lit_act, lit_exp);
      lit_seen = lit_seq;
    end
  end

  task automatic post_lit(input string nm, input logic [63:0] act, input logic [63:0] ex);
    lit_name = nm;
    lit_act  = act;
    lit_exp  = ex;
    lit_seq++;
    @(negedge clk);
    #1;
  endtask

  // Model state carried between runs (sticky outputs seen while idle).
  logic          m_err = 1'b0;
  logic [NC-1:0] m_err_core = '0;
  logic [CW-1:0] m_cnt = '0;
  int            m_done_c = 0;

  logic [NC-1:0] wave [MAXC];
  int            rise_a [NC];
  int            len_a [NC];

  // One run: cycle 0 carries the start edge, cycle 1 is the launch cycle.
  task automatic run(input logic [NC-1:0] en_l, input bit noise, input bit tog, input int abort_at);
    logic [NC-1:0] acc, acked, n_err_core;
    logic          n_err;
    int            a, r, done_c, err_vis, snap;
    for (int j = 0; j < MAXC; j++) begin
      logic [NC-1:0] w;
      w = '0;
      for (int c = 0; c < NC; c++)
        if (en_l[c] && rise_a[c] >= 0 && j >= rise_a[c] && j < rise_a[c] + len_a[c]) w[c] = 1'b1;
      if (noise) w = w | (NC'($urandom) & ~en_l);
      wave[j] = w;
    end
    n_err_core = '0;
    if (en_l == '0) begin
      n_err = 1'b1; r = 0; done_c = 1; err_vis = 1;
    end else begin
      acc = '0; a = -1; n_err = 1'b0; acked = en_l;
      for (int j = 2; j <= 1 + AT; j++) begin
        acc = acc | (wave[j] & en_l);
        if (acc == en_l) begin a = j; break; end
      end
      if (a < 0) begin
        a = 1 + AT; n_err = 1'b1; n_err_core = en_l & ~acc; acked = acc;
      end
      err_vis = a + 1;
      if (acked == '0) begin
        r = a; done_c = a + 1;
      end else begin
        r = a + 1;
        while (r < MAXC - 4 && (wave[r] & acked) != '0) r++;
        done_c = r + 1;
      end
    end
    m_done_c = done_c;

    @(posedge clk); #1;
    cyc = -1; start = 1'b0; core_en = NC'($urandom); core_busy = NC'($urandom);
    e_start = '0; e_busy = 1'b0; e_done = 1'b0; e_err = m_err; e_err_core = m_err_core; e_cnt = m_cnt;

    for (int j = 0; j <= done_c + 2; j++) begin
      @(posedge clk); #1;
      cyc = j;
      if (j == 0 || j >= done_c) start = 1'b1;
      else if (tog) start = ($urandom_range(0, 1) == 1);
      else start = 1'b1;
      core_en   = (j == 0) ? en_l : NC'($urandom);
      core_busy = wave[j];
      e_start = (j == 1 && en_l != '0) ? en_l : '0;
      e_busy  = (en_l != '0) && (j >= 1) && (j < done_c);
      e_done  = (j == done_c);
      if (j == 0) begin
        e_err = m_err; e_err_core = m_err_core; e_cnt = m_cnt;
      end else begin
        e_err      = (j >= err_vis) ? n_err : 1'b0;
        e_err_core = (j >= err_vis) ? n_err_core : '0;
        e_cnt      = PERF ? CW'((j - 1 < r) ? j - 1 : r) : '0;
      end
      if (j == abort_at) begin
        rst_n = 1'b0;
        e_start = '0; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0; e_err_core = '0; e_cnt = '0;
        m_err = 1'b0; m_err_core = '0; m_cnt = '0;
        #1;
        post_lit("async_reset_outputs", 64'({core_start, busy_o, done_o, err_o, err_core, cyc_cnt}), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        rst_n = 1'b1;
        snap = obs_done_total;
        repeat (4) @(posedge clk);
        #1;
        post_lit("no_done_after_reset", 64'(obs_done_total - snap), 64'd0);
        return;
      end
    end
    m_err = n_err; m_err_core = n_err_core;
    m_cnt = PERF ? CW'(r) : '0;
  endtask

  task automatic set_core(input int c, input int rise, input int len);
    rise_a[c] = rise;
    len_a[c]  = len;
  endtask

  initial begin
    int snap;
    rst_n = 1'b0; start = 1'b0; core_en = '0; core_busy = '0;
    #12;
    post_lit("reset_outputs", 64'({core_start, busy_o, done_o, err_o, err_core, cyc_cnt}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);

    // All four cores busy from cycle 3 for 10/20/30/40 cycles; start toggled mid-run.
    set_core(0, 3, 10); set_core(1, 3, 20); set_core(2, 3, 30); set_core(3, 3, 40);
    snap = obs_done_total;
    run(4'b1111, 1'b0, 1'b1, -1);
    post_lit("t1_model_done", 64'(m_done_c), 64'd44);
    post_lit("t1_done_cycle", 64'(obs_done_cyc), 64'd44);
    post_lit("t1_single_done", 64'(obs_done_total - snap), 64'd1);
    post_lit("t1_err", 64'(obs_err), 64'd0);
`ifdef MATMUL_PERF_CNT_EN
    post_lit("t1_cycle_count", 64'(obs_cnt), 64'd43);
`endif

    // Cores 1 and 3 disabled and silent.
    set_core(0, 2, 5); set_core(1, -1, 1); set_core(2, 4, 8); set_core(3, -1, 1);
    run(4'b0101, 1'b0, 1'b0, -1);
    post_lit("t2_done_cycle", 64'(obs_done_cyc), 64'd13);
    post_lit("t2_err", 64'(obs_err), 64'd0);

    // Core 2 never acknowledges.
    set_core(0, 3, 25); set_core(1, 3, 25); set_core(2, -1, 1); set_core(3, 3, 25);
    run(4'b1111, 1'b1, 1'b0, -1);
    post_lit("t3_done_cycle", 64'(obs_done_cyc), 64'd29);
    post_lit("t3_err", 64'(obs_err), 64'd1);
    post_lit("t3_err_core", 64'(obs_err_core), 64'h4);
`ifdef MATMUL_PERF_CNT_EN
    post_lit("t3_cycle_count", 64'(obs_cnt), 64'd28);
`endif

    // Empty mask.
    run(4'b0000, 1'b1, 1'b0, -1);
    post_lit("t4_done_cycle", 64'(obs_done_cyc), 64'd1);
    post_lit("t4_err", 64'(obs_err), 64'd1);

    // Reset asserted during RUN, then a fresh launch.
    set_core(0, 3, 30); set_core(1, 3, 30); set_core(2, 3, 30); set_core(3, 3, 30);
    run(4'b1111, 1'b1, 1'b0, 10);
    set_core(0, 2, 5); set_core(1, -1, 1); set_core(2, 4, 8); set_core(3, -1, 1);
    run(4'b0101, 1'b0, 1'b0, -1);
    post_lit("t6_relaunch_done_cycle", 64'(obs_done_cyc), 64'd13);

    for (int k = 0; k < 40; k++) begin
      for (int c = 0; c < NC; c++) begin
        if ($urandom_range(0, 9) == 0) set_core(c, -1, 1);
        else set_core(c, 2 + int'($urandom_range(0, 17)), 1 + int'($urandom_range(0, 19)));
      end
      run(NC'($urandom), 1'b1, ($urandom_range(0, 1) == 1), -1);
    end

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
